mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, SHALL set the RAM size to 2^DEPTH_LOG2 32-bit words.
REQ-002 Parameter WAIT, default 2, range 0..15, SHALL set the wait states inserted before each response.
REQ-003 Parameter IO_ADDR, default 32'hFFFF_FFF0, SHALL set the word address of the output port register.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req  input  1  initiator request strobe; sampled only in IDLE.
REQ-007 rw  input  1  1 = read, 0 = write.
REQ-008 address  input  32  word address from initiator.
REQ-009 wdata  input  32  write data from initiator.
REQ-010 rdata  output  32  read data to initiator.
REQ-011 ready  output  1  one-cycle completion pulse.
REQ-012 err  output  1  one-cycle error pulse, coincident with ready.
REQ-013 io_out  output  32  output port register.
REQ-014 io_strobe  output  1  one-cycle pulse when io_out is written.

Function
REQ-015 FSM SHALL have exactly three states: IDLE, WAIT, DONE.
REQ-016 IDLE with req=1 SHALL latch address, rw and wdata, load the wait counter with WAIT, and go to WAIT (WAIT>0) or DONE (WAIT=0).
REQ-017 WAIT SHALL decrement the counter each cycle and go to DONE on the edge where the counter goes from 1 to 0.
REQ-018 ready SHALL be 1 exactly for the one cycle the FSM is in DONE; latency from the accepting edge to ready high SHALL be WAIT+1 cycles.
REQ-019 DONE SHALL always go to IDLE on the next edge.
REQ-020 Back-to-back requests with req held high SHALL be accepted in the IDLE cycle after DONE.
REQ-021 A new request SHALL never be accepted in WAIT or DONE.
REQ-022 req, rw, address and wdata changes after acceptance SHALL not affect the transaction in flight.
REQ-023 A latched address below 2^DEPTH_LOG2 SHALL select the RAM word at address[DEPTH_LOG2-1:0].
REQ-024 An address equal to IO_ADDR SHALL select io_out.
REQ-025 Any other address SHALL be out of range.
REQ-026 A RAM write SHALL commit on the edge entering DONE.
REQ-027 A RAM read SHALL present the word on rdata while ready=1.
REQ-028 A read of a word written by the immediately preceding transaction SHALL return the new value.
REQ-029 An IO write SHALL update io_out on the edge entering DONE and pulse io_strobe coincident with ready.
REQ-030 An IO read SHALL return io_out with io_strobe=0.
REQ-031 An out-of-range access SHALL pulse err with ready, drive rdata=0, and discard any write.
REQ-032 Outside DONE, rdata SHALL hold its last value, and ready, err and io_strobe SHALL be 0.

Reset
REQ-033 reset=0 SHALL asynchronously force: FSM to IDLE, counter to 0, rdata 0, ready 0, err 0, io_out 0, io_strobe 0.
REQ-034 A reset asserted mid-transaction SHALL abort it with no ready pulse and no RAM or IO write.
REQ-035 RAM contents SHALL not be cleared by reset.
REQ-036 After reset deassertion, the first edge with req=1 SHALL be accepted.

Verification
REQ-037 Write-then-read (WAIT=2): write 32'hDEADBEEF to addr 5, then read addr 5 -> ready exactly 3 cycles after each accept; rdata=32'hDEADBEEF; err=0.
REQ-038 IO write: write 32'h0000_00A5 to IO_ADDR -> io_out=32'hA5 and io_strobe=1 in the same cycle as ready; subsequent IO read returns 32'hA5.
REQ-039 Out of range (DEPTH_LOG2=10): read addr 32'h400 -> ready=1, err=1, rdata=0; write 7 to addr 32'h400 then read addr 0 -> addr 0 contents unchanged.
REQ-040 Back-to-back: req held high for 4 reads of addrs 0..3 with WAIT=0 -> ready on every second cycle, 4 pulses, data in order.
REQ-041 Reset mid-op: assert reset during WAIT of a write of 9 to addr 2 -> no ready pulse; addr 2 retains its prior value; io_out=0.
REQ-042 WAIT=0 corner: single read -> ready exactly 1 cycle after the accepting edge.

Source files
------------

// File: rtl/mem_responder.sv
// Word-addressed RAM plus one output-port register behind a
// req/ready handshake with a programmable number of wait states.
module mem_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter int          WAIT       = 2,
    parameter logic [31:0] IO_ADDR    = 32'hFFFF_FFF0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        rw,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic [31:0] io_out,
    output logic        io_strobe
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic        r_rw;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_ram [2**DEPTH_LOG2];

    logic                  w_accept;
    logic                  w_enter_done;
    logic                  w_rw;
    logic [31:0]           w_addr;
    logic [31:0]           w_wdata;
    logic                  w_ram_sel;
    logic                  w_io_sel;
    logic [DEPTH_LOG2-1:0] w_idx;

    assign w_accept     = (r_state == S_IDLE) && req;
    assign w_enter_done = (w_next == S_DONE) && (r_state != S_DONE);

    // With no wait states the access completes on the accepting edge,
    // so the live inputs are used before they reach the latches.
    assign w_rw      = w_accept ? rw      : r_rw;
    assign w_addr    = w_accept ? address : r_addr;
    assign w_wdata   = w_accept ? wdata   : r_wdata;
    assign w_ram_sel = (w_addr[31:DEPTH_LOG2] == '0);
    assign w_io_sel  = (w_addr == IO_ADDR);
    assign w_idx     = w_addr[DEPTH_LOG2-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_cnt_next = WAIT_CNT;
                    w_next     = (WAIT_CNT == 4'd0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rw    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else if (w_accept) begin
            r_rw    <= rw;
            r_addr  <= address;
            r_wdata <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata     <= 32'd0;
            ready     <= 1'b0;
            err       <= 1'b0;
            io_out    <= 32'd0;
            io_strobe <= 1'b0;
        end else begin
            ready     <= w_enter_done;
            err       <= w_enter_done && !w_ram_sel && !w_io_sel;
            io_strobe <= w_enter_done && w_io_sel && !w_ram_sel && !w_rw;
            if (w_enter_done) begin
                if (!w_ram_sel && !w_io_sel) begin
                    rdata <= 32'd0;
                end else if (w_rw) begin
                    rdata <= w_ram_sel ? r_ram[w_idx] : io_out;
                end
                if (w_io_sel && !w_ram_sel && !w_rw) begin
                    io_out <= w_wdata;
                end
            end
        end
    end

    // RAM is deliberately outside the reset domain; a held reset blocks writes.
    always_ff @(posedge clk) begin
        if (reset && w_enter_done && w_ram_sel && !w_rw) begin
            r_ram[w_idx] <= w_wdata;
        end
    end

endmodule
